// File: rtl/tff_counter_pkg.sv
// Shared constants for the T flip-flop counter family.
// Direction and wrap/saturate mode encodings.
package tff_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/tff_counter_cell.sv
// One T flip-flop with sync reset, clear and load.
// qbar is its own register so it never lags q.
module tff_counter_cell
    import tff_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic ld,
    input  logic ld_val,
    input  logic t,
    output logic q,
    output logic qbar
);

    // Priority: reset, clear, load, then toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            qbar <= 1'b1;
        end else if (clr) begin
            q    <= 1'b0;
            qbar <= 1'b1;
        end else if (ld) begin
            q    <= ld_val;
            qbar <= ~ld_val;
        end else if (t) begin
            q    <= ~q;
            qbar <= q;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// Up/down counter from a bank of T flip-flop cells.
// Wrap or saturate at the limit, with tc and a wrap pulse.
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic SAT_EN = (SATURATE == MODE_SAT);

    logic             dir_up;
    logic [WIDTH:0]   chain;
    logic [WIDTH-1:0] t;
    logic             cnt;

    assign dir_up   = (up == DIR_UP);
    assign chain[0] = 1'b1;

    // chain[i] is 1 when all lower bits sit at the
    // direction's carry/borrow value; chain[WIDTH] is tc.
    assign tc  = chain[WIDTH];
    assign cnt = en & ~(SAT_EN & tc);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign chain[i+1] = chain[i]
                              & (dir_up ? q[i] : ~q[i]);
            assign t[i] = cnt & chain[i];

            tff_counter_cell u_cell (
                .clk    (clk),
                .rst    (rst),
                .clr    (clear),
                .ld     (load),
                .ld_val (load_val[i]),
                .t      (t[i]),
                .q      (q[i]),
                .qbar   (qbar[i])
            );
        end
    endgenerate

    // Pulse one cycle after an edge that rolled past the limit.
    always_ff @(posedge clk) begin
        if (rst || clear || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= en & tc & ~SAT_EN;
        end
    end

endmodule
